// File: rtl/menu_nav_ctrl.sv
// Menu/navigation controller: game state, menu selection, palette, pixel scale and layout req/ack.
// Optional build macro MENU_PIX_WRAP_EN: scale +1 from PIX_MAX wraps to PIX_MIN instead of saturating.
module menu_nav_ctrl #(
  parameter int MENU_ITEMS  = 3,
  parameter int OPT_ITEMS   = 3,
  parameter int PALETTES    = 4,
  parameter int PIX_MIN     = 1,
  parameter int PIX_MAX     = 6,
  parameter int PIX_DEFAULT = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        btn_pal_i,
  input  logic        btn_next_i,
  input  logic        btn_prev_i,
  input  logic        btn_sel_i,
  input  logic        game_exit_i,
  input  logic        layout_ack_i,
  output logic [1:0]  state_o,
  output logic [3:0]  sel_o,
  output logic [3:0]  palette_id_o,
  output logic [3:0]  pix_w_o,
  output logic [3:0]  pix_h_o,
  output logic        layout_req_o,
  output logic [2:0]  game_btn_o,
  output logic [19:0] seg_vals_o,
  output logic [3:0]  leds_o
);

  typedef enum logic [1:0] {
    ST_MAIN = 2'd0,
    ST_OPT  = 2'd1,
    ST_GAME = 2'd2
  } state_t;

  localparam logic [3:0] MENU_LAST = 4'(MENU_ITEMS - 1);
  localparam logic [3:0] OPT_LAST  = 4'(OPT_ITEMS - 1);
  localparam logic [3:0] PAL_LAST  = 4'(PALETTES - 1);
  localparam logic [3:0] PMIN      = 4'(PIX_MIN);
  localparam logic [3:0] PMAX      = 4'(PIX_MAX);
  localparam logic [3:0] PDEF      = 4'(PIX_DEFAULT);

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] pal_q, pal_d;
  logic [3:0] pix_q, pix_d;
  logic       req_q, req_d;
  logic [2:0] game_btn_q, game_btn_d;
  logic [3:0] last_item;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pal_d      = pal_q;
    pix_d      = pix_q;
    game_btn_d = 3'b000;
    last_item  = (state_q == ST_MAIN) ? MENU_LAST : OPT_LAST;

    if (btn_pal_i) begin
      pal_d = (pal_q >= PAL_LAST) ? 4'd0 : pal_q + 4'd1;
    end

    case (state_q)
      ST_MAIN, ST_OPT: begin
        if (btn_sel_i) begin
          if (state_q == ST_MAIN) begin
            if (sel_q == 4'd0) begin
              state_d = ST_GAME;
              sel_d   = 4'd0;
            end else if (sel_q == 4'd1) begin
              state_d = ST_OPT;
              sel_d   = 4'd0;
            end
          end else begin
            // Last options entry is "back"; checked first so it never aliases items 0/1.
            if (sel_q == OPT_LAST) begin
              state_d = ST_MAIN;
              sel_d   = 4'd0;
            end else if (sel_q == 4'd0) begin
`ifdef MENU_PIX_WRAP_EN
              pix_d = (pix_q >= PMAX) ? PMIN : pix_q + 4'd1;
`else
              pix_d = (pix_q >= PMAX) ? pix_q : pix_q + 4'd1;
`endif
            end else if (sel_q == 4'd1) begin
              pix_d = (pix_q <= PMIN) ? pix_q : pix_q - 4'd1;
            end
          end
        end else if (btn_next_i && !btn_prev_i) begin
          sel_d = (sel_q >= last_item) ? 4'd0 : sel_q + 4'd1;
        end else if (btn_prev_i && !btn_next_i) begin
          sel_d = (sel_q == 4'd0) ? last_item : sel_q - 4'd1;
        end
      end
      ST_GAME: begin
        if (game_exit_i) begin
          state_d = ST_MAIN;
          sel_d   = 4'd0;
        end else begin
          game_btn_d = {btn_sel_i, btn_prev_i, btn_next_i};
        end
      end
      default: begin
        state_d = ST_MAIN;
        sel_d   = 4'd0;
      end
    endcase

    // A scale change in the ack cycle must keep the request pending.
    if (pix_d != pix_q) begin
      req_d = 1'b1;
    end else if (layout_ack_i) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_MAIN;
      sel_q      <= 4'd0;
      pal_q      <= 4'd0;
      pix_q      <= PDEF;
      req_q      <= 1'b1;
      game_btn_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pal_q      <= pal_d;
      pix_q      <= pix_d;
      req_q      <= req_d;
      game_btn_q <= game_btn_d;
    end
  end

  assign state_o      = state_q;
  assign sel_o        = sel_q;
  assign palette_id_o = pal_q;
  assign pix_w_o      = pix_q;
  assign pix_h_o      = pix_q;
  assign layout_req_o = req_q;
  assign game_btn_o   = game_btn_q;
  assign leds_o       = sel_q;
  assign seg_vals_o   = {1'b0, 2'b00, state_q, 1'b1, pix_q, 1'b0, pal_q, 1'b0, sel_q};

endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Scoreboard bench for menu_nav_ctrl: directed walk through the menu flow, then randomized pulses.
module tb_menu_nav_ctrl;

  localparam int MENU_ITEMS  = 3;
  localparam int OPT_ITEMS   = 3;
  localparam int PALETTES    = 4;
  localparam int PIX_MIN     = 1;
  localparam int PIX_MAX     = 6;
  localparam int PIX_DEFAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_pal = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_sel = 1'b0;
  logic        game_exit = 1'b0, layout_ack = 1'b0;
  logic [1:0]  state;
  logic [3:0]  sel, palette_id, pix_w, pix_h, leds;
  logic        layout_req;
  logic [2:0]  game_btn;
  logic [19:0] seg_vals;

  menu_nav_ctrl #(
    .MENU_ITEMS(MENU_ITEMS), .OPT_ITEMS(OPT_ITEMS), .PALETTES(PALETTES),
    .PIX_MIN(PIX_MIN), .PIX_MAX(PIX_MAX), .PIX_DEFAULT(PIX_DEFAULT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .btn_pal_i(btn_pal), .btn_next_i(btn_next), .btn_prev_i(btn_prev), .btn_sel_i(btn_sel),
    .game_exit_i(game_exit), .layout_ack_i(layout_ack),
    .state_o(state), .sel_o(sel), .palette_id_o(palette_id),
    .pix_w_o(pix_w), .pix_h_o(pix_h), .layout_req_o(layout_req),
    .game_btn_o(game_btn), .seg_vals_o(seg_vals), .leds_o(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, sl, pal, pix, req, gb;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (plain integers).
  int m_st = 0, m_sl = 0, m_pal = 0, m_pix = PIX_DEFAULT, m_req = 1, m_gb = 0;

  task automatic step(input bit rst, input bit pal, input bit nxt, input bit prv,
                      input bit sl, input bit ex, input bit ack);
    int n, npix;
    exp_t e;
    @(negedge clk);
    rst_n = ~rst; btn_pal = pal; btn_next = nxt; btn_prev = prv;
    btn_sel = sl; game_exit = ex; layout_ack = ack;
    if (rst) begin
      m_st = 0; m_sl = 0; m_pal = 0; m_pix = PIX_DEFAULT; m_req = 1; m_gb = 0;
    end else begin
      if (pal) m_pal = (m_pal + 1) % PALETTES;
      npix = m_pix;
      m_gb = 0;
      if (m_st == 2) begin
        if (ex) begin m_st = 0; m_sl = 0; end
        else m_gb = 4 * sl + 2 * prv + nxt;
      end else begin
        n = (m_st == 0) ? MENU_ITEMS : OPT_ITEMS;
        if (sl) begin
          if (m_st == 0) begin
            if (m_sl == 0) begin m_st = 2; m_sl = 0; end
            else if (m_sl == 1) begin m_st = 1; m_sl = 0; end
          end else if (m_sl == OPT_ITEMS - 1) begin
            m_st = 0; m_sl = 0;
          end else if (m_sl == 0) begin
`ifdef MENU_PIX_WRAP_EN
            npix = (m_pix == PIX_MAX) ? PIX_MIN : m_pix + 1;
`else
            npix = (m_pix + 1 > PIX_MAX) ? PIX_MAX : m_pix + 1;
`endif
          end else if (m_sl == 1) begin
            npix = (m_pix - 1 < PIX_MIN) ? PIX_MIN : m_pix - 1;
          end
        end else if (nxt != prv) begin
          m_sl = nxt ? (m_sl + 1) % n : (m_sl + n - 1) % n;
        end
      end
      if (npix != m_pix) m_req = 1;
      else if (ack) m_req = 0;
      m_pix = npix;
    end
    e.st = m_st; e.sl = m_sl; e.pal = m_pal; e.pix = m_pix; e.req = m_req; e.gb = m_gb;
    exp_q.push_back(e);
  endtask

  // Monitor: each cycle the DUT presents a fresh output set; compare it with the oldest expectation.
  initial begin
    exp_t e;
    int   seg_exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        seg_exp = e.sl + 32 * e.pal + 1024 * (16 + e.pix) + 32768 * e.st;
        vectors++;
        if (int'(state) != e.st || int'(sel) != e.sl || int'(palette_id) != e.pal ||
            int'(pix_w) != e.pix || int'(pix_h) != e.pix || int'(layout_req) != e.req ||
            int'(game_btn) != e.gb || int'(seg_vals) != seg_exp || int'(leds) != e.sl) begin
          miscompares++;
          $display("FAIL vec%0d outputs: got st=%0d sel=%0d pal=%0d pw=%0d ph=%0d req=%0d gb=%0d seg=%05h leds=%0d ; want st=%0d sel=%0d pal=%0d pix=%0d req=%0d gb=%0d seg=%05h",
                   vectors, state, sel, palette_id, pix_w, pix_h, layout_req, game_btn,
                   seg_vals, leds, e.st, e.sl, e.pal, e.pix, e.req, e.gb, seg_exp);
        end
      end
    end
  end

  initial begin
    //   rst pal nxt prv sel ex ack
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);   // ack clears initial request
    step(0, 0, 0, 0, 0, 0, 1);   // ack with req low ignored
    step(0, 0, 0, 1, 0, 0, 0);   // prev wraps to 2
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);   // both: hold
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);   // item 1 -> options
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);   // back -> main
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);   // -> options
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, (i == 3)); // up to 6, then wrap/saturate
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);   // item 1
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 0); // down to PIX_MIN, saturated
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0);   // item 0
    step(0, 0, 0, 0, 1, 0, 1);   // scale change races ack
    step(0, 0, 0, 0, 0, 0, 1);   // second ack clears
    step(0, 0, 0, 1, 0, 0, 0);   // last item
    step(0, 0, 0, 0, 1, 0, 0);   // -> main
    step(0, 0, 0, 0, 1, 0, 0);   // item 0 -> game
    step(0, 0, 1, 0, 0, 0, 0);   // game_btn 001
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0);   // exit wins
    step(0, 0, 0, 0, 0, 1, 0);   // exit outside game ignored
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    btn_pal = 0; btn_next = 0; btn_prev = 0; btn_sel = 0; game_exit = 0; layout_ack = 0;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
